// File: rtl/bb_lpf_decim.sv
// bb_lpf_decim -- accumulate-and-dump low-pass decimator for the baseband
// I/Q pair coming out of the IQ demodulator.
//
// Sums DECIM = 2**LOG2_DECIM consecutive valid samples per channel, then
// emits one scaled (>>> SHIFT), saturated sample pair with a one-cycle
// lpf_rdy strobe. I and Q share phase and control and are dumped together.
//
// Ports:
//   clk        system clock, rising edge
//   resetn     asynchronous active-low reset
//   demod_rdy  input valid qualifier for I_BB/Q_BB
//   I_BB, Q_BB signed baseband samples, IN_W bits
//   lpf_clr    synchronous realign: drop partial block, restart at phase 0
//   I_LP, Q_LP signed decimated samples, OUT_W bits, held between dumps
//   lpf_rdy    one-cycle strobe, I_LP/Q_LP updated this cycle
//   lpf_sat    sticky: some output clipped since reset or lpf_clr
//
// Optional feature: define BB_LPF_ROUND_EN to round half up before the
// shift (adds 2**(SHIFT-1)); undefined gives a plain truncating shift.

module bb_lpf_decim #(
    parameter int IN_W       = 5,
    parameter int LOG2_DECIM = 2,
    parameter int SHIFT      = 2,
    parameter int OUT_W      = 5
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    demod_rdy,
    input  logic signed [IN_W-1:0]  I_BB,
    input  logic signed [IN_W-1:0]  Q_BB,
    input  logic                    lpf_clr,
    output logic signed [OUT_W-1:0] I_LP,
    output logic signed [OUT_W-1:0] Q_LP,
    output logic                    lpf_rdy,
    output logic                    lpf_sat
);

    localparam int DECIM = 1 << LOG2_DECIM;
    localparam int ACC_W = IN_W + LOG2_DECIM;
    // One guard bit so the rounding offset can never wrap the sum.
    localparam int EXT_W = ACC_W + 1;
    localparam int PH_W  = (LOG2_DECIM > 0) ? LOG2_DECIM : 1;

    localparam logic [PH_W-1:0] PH_LAST = PH_W'(DECIM - 1);
    localparam logic [PH_W-1:0] PH_ONE  = PH_W'(1);

    localparam logic signed [EXT_W-1:0] OUT_MAX = EXT_W'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [EXT_W-1:0] OUT_MIN = EXT_W'(-(1 << (OUT_W - 1)));

`ifdef BB_LPF_ROUND_EN
    localparam int RND_SH = (SHIFT > 0) ? SHIFT - 1 : 0;
    localparam logic signed [EXT_W-1:0] RND = (SHIFT > 0) ? EXT_W'(1 << RND_SH) : '0;
`else
    localparam logic signed [EXT_W-1:0] RND = '0;
`endif

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t                  state;
    logic signed [ACC_W-1:0] acc_i;
    logic signed [ACC_W-1:0] acc_q;
    logic [PH_W-1:0]         phase;

    logic signed [ACC_W-1:0] sum_i;
    logic signed [ACC_W-1:0] sum_q;
    logic signed [OUT_W-1:0] dump_i;
    logic signed [OUT_W-1:0] dump_q;
    logic                    clip_i;
    logic                    clip_q;
    logic                    dump;

    // Returns {clipped, value}: optional rounding offset, arithmetic shift
    // (floor), then clamp to the signed OUT_W range.
    function automatic logic [OUT_W:0] scale(input logic signed [ACC_W-1:0] s);
        logic signed [EXT_W-1:0] e;
        e = EXT_W'(s) + RND;
        e = e >>> SHIFT;
        if (e > OUT_MAX) begin
            return {1'b1, OUT_MAX[OUT_W-1:0]};
        end else if (e < OUT_MIN) begin
            return {1'b1, OUT_MIN[OUT_W-1:0]};
        end
        return {1'b0, e[OUT_W-1:0]};
    endfunction

    always_comb begin
        sum_i            = acc_i + ACC_W'(I_BB);
        sum_q            = acc_q + ACC_W'(Q_BB);
        {clip_i, dump_i} = scale(sum_i);
        {clip_q, dump_q} = scale(sum_q);
        dump             = demod_rdy &&
                           ((state == IDLE) ? (DECIM == 1) : (phase == PH_LAST));
    end

    // IDLE always holds acc = 0 and phase = 0, so its "load acc = sample,
    // phase = 1" is the same update as RUN's accumulate step; both states
    // share that path and differ only in when a dump is taken.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= IDLE;
            acc_i   <= '0;
            acc_q   <= '0;
            phase   <= '0;
            I_LP    <= '0;
            Q_LP    <= '0;
            lpf_rdy <= 1'b0;
            lpf_sat <= 1'b0;
        end else if (lpf_clr) begin
            // Clear beats any concurrent sample or dump; outputs hold.
            state   <= IDLE;
            acc_i   <= '0;
            acc_q   <= '0;
            phase   <= '0;
            lpf_rdy <= 1'b0;
            lpf_sat <= 1'b0;
        end else begin
            lpf_rdy <= 1'b0;
            if (demod_rdy) begin
                state <= RUN;
                if (dump) begin
                    acc_i   <= '0;
                    acc_q   <= '0;
                    phase   <= '0;
                    I_LP    <= dump_i;
                    Q_LP    <= dump_q;
                    lpf_rdy <= 1'b1;
                    lpf_sat <= lpf_sat | clip_i | clip_q;
                end else begin
                    acc_i <= sum_i;
                    acc_q <= sum_q;
                    phase <= phase + PH_ONE;
                end
            end
        end
    end

endmodule
